// File: rtl/lane_deserializer.sv
// Per-lane receive front end: serial bit stream in, comma-aligned 32-bit words out.
// Finds byte alignment from repeated comma symbols, then packs four data bytes
// (first byte in [31:24]) into a word presented with a one-cycle valid strobe.
module lane_deserializer #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] lane_out,
    output logic        valid_out,
    output logic        active,
    output logic        sym_err
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {StSearch, StAlign, StLocked} state_e;

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  comma_cnt_q;
    logic [3:0]  comma_inc;
    logic [1:0]  byte_idx_q;
    logic [31:0] word_q;
    logic [31:0] word_ins;
    logic [31:0] lane_q;
    logic        valid_q;
    logic        active_q;
    logic        err_q;
    logic        boundary;
    logic        is_ctrl;

    // Next shift contents, byte-boundary detect and the word with the new byte slotted in.
    always_comb begin
        shift_d   = {shift_q[6:0], data_in};
        boundary  = (bit_cnt_q == 3'd7);
        is_ctrl   = (shift_d == COMMA) || (shift_d == IDLE);
        comma_inc = comma_cnt_q + 4'd1;
        word_ins  = word_q;
        case (byte_idx_q)
            2'd0:    word_ins[31:24] = shift_d;
            2'd1:    word_ins[23:16] = shift_d;
            2'd2:    word_ins[15:8]  = shift_d;
            default: word_ins[7:0]   = shift_d;
        endcase
    end

    // Alignment FSM, word assembly and registered outputs.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= StSearch;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'h0;
            lane_q      <= 32'h0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    // Sliding search: any bit position may start a comma.
                    if (shift_d == COMMA) begin
                        bit_cnt_q   <= 3'd0;
                        comma_cnt_q <= 4'd1;
                        if (LockCnt == 4'd1) begin
                            state_q  <= StLocked;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    if (boundary) begin
                        if (shift_d == COMMA) begin
                            comma_cnt_q <= comma_inc;
                            if (comma_inc == LockCnt) begin
                                state_q  <= StLocked;
                                active_q <= 1'b1;
                            end
                        end else begin
                            comma_cnt_q <= 4'd0;
                            state_q     <= StSearch;
                        end
                    end
                end
                StLocked: begin
                    if (boundary) begin
                        if (is_ctrl) begin
                            // A control symbol inside a word means the partial word is bad.
                            if (byte_idx_q != 2'd0) begin
                                byte_idx_q <= 2'd0;
                                word_q     <= 32'h0;
                                err_q      <= 1'b1;
                            end
                        end else if (byte_idx_q == 2'd3) begin
                            lane_q     <= word_ins;
                            valid_q    <= 1'b1;
                            byte_idx_q <= 2'd0;
                            word_q     <= 32'h0;
                        end else begin
                            word_q     <= word_ins;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

    assign lane_out  = lane_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign sym_err   = err_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// Self-checking bench for lane_deserializer: vector table, directed corner
// sequences and a randomized symbol stream against a byte-level reference model.
module tb_lane_deserializer;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;
    localparam int         LOCK  = 4;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_in;
    logic [31:0] lane_out;
    logic        valid_out;
    logic        active;
    logic        sym_err;

    lane_deserializer #(
        .COMMA      (COMMA),
        .IDLE       (IDLE),
        .LOCK_COUNT (LOCK)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .lane_out  (lane_out),
        .valid_out (valid_out),
        .active    (active),
        .sym_err   (sym_err)
    );

    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed-event tallies for the directed sequences.
    int          n_valid;
    int          n_err;
    logic [31:0] last_word;

    // Reference model: last 8 bits seen, bits since alignment, commas counted,
    // and the bytes of the word being collected.
    logic [7:0]  m_win;
    bit          m_synced;
    int          m_bits;
    int          m_commas;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_lane;
    logic        m_valid;
    logic        m_err;
    logic        m_active;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[5];

    function automatic void model_reset();
        m_win    = 8'h00;
        m_synced = 0;
        m_bits   = 0;
        m_commas = 0;
        m_bytes.delete();
        m_lane   = 32'h0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_active = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_active) begin
            if (b == COMMA) begin
                m_commas++;
                if (m_commas >= LOCK) m_active = 1'b1;
            end else begin
                m_commas = 0;
                m_synced = 0;
            end
        end else if (b == COMMA || b == IDLE) begin
            if (m_bytes.size() > 0) begin
                m_err = 1'b1;
                m_bytes.delete();
            end
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                m_lane  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_valid = 1'b1;
                m_bytes.delete();
            end
        end
    endfunction

    function automatic void model_step(input logic b);
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_win   = {m_win[6:0], b};
        if (!m_synced) begin
            if (m_win == COMMA) begin
                m_synced = 1;
                m_bits   = 0;
                m_commas = 1;
                if (m_commas >= LOCK) m_active = 1'b1;
            end
        end else begin
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                model_byte(m_win);
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one bit, let the edge sample it, then compare against the model.
    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(b);
        if (valid_out) begin
            n_valid++;
            last_word = lane_out;
        end
        if (sym_err) n_err++;
        check("lane_out", lane_out, m_lane);
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("active", 32'(active), 32'(m_active));
        check("sym_err", 32'(sym_err), 32'(m_err));
        check("valid_err_excl", 32'(valid_out & sym_err), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic clear_mon();
        n_valid   = 0;
        n_err     = 0;
        last_word = 32'h0;
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        reset   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_32f);
        #1;
        check("rst_lane", lane_out, 32'h0);
        check("rst_flags", {29'h0, valid_out, active, sym_err}, 32'h0);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic lock();
        for (int i = 0; i < LOCK; i++) send_byte(COMMA);
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h23, 8'h45, 8'h67, 32'h01234567};
        vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
        vecs[2] = '{8'hBD, 8'h7D, 8'hBB, 8'h3C, 32'hBD7DBB3C};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[4] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 32'h5AA5C33C};

        reset   = 1'b1;
        data_in = 1'b0;

        // Idle zeros after reset: nothing happens.
        do_reset();
        repeat (64) tick(1'b0);
        check("idle_valid_cnt", n_valid, 0);
        check("idle_active", 32'(active), 32'h0);

        // Garbage bits, lock, all-ones word with one-cycle latency.
        do_reset();
        tick(1'b0); tick(1'b1); tick(1'b0);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        check("no_active_3_commas", 32'(active), 32'h0);
        send_byte(COMMA);
        check("active_after_4th", 32'(active), 32'h1);
        for (int i = 0; i < 4; i++) send_byte(8'hFF);
        check("ff_valid_now", 32'(valid_out), 32'h1);
        tick(1'b0);
        check("ff_valid_one_cycle", 32'(valid_out), 32'h0);
        check("ff_valid_cnt", n_valid, 1);
        check("ff_word", last_word, 32'hFFFFFFFF);

        // Comma inside a word drops the partial word.
        do_reset();
        lock();
        send_byte(8'h88); send_byte(8'h88); send_byte(COMMA);
        check("comma_err_now", 32'(sym_err), 32'h1);
        for (int i = 0; i < 4; i++) send_byte(8'h88);
        check("comma_err_cnt", n_err, 1);
        check("comma_valid_cnt", n_valid, 1);
        check("comma_word", last_word, 32'h88888888);

        // Idle after a lone data byte errors; idles between words do not.
        do_reset();
        lock();
        send_byte(IDLE); send_byte(IDLE); send_byte(8'h99); send_byte(IDLE);
        check("idle_err_now", 32'(sym_err), 32'h1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(IDLE); send_byte(IDLE);
        check("idle_err_cnt", n_err, 1);
        check("idle_valid_cnt2", n_valid, 1);
        check("idle_word", last_word, 32'h11223344);

        // Broken comma run falls back to search; second run locks.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        send_byte(8'h77);
        check("broken_no_active", 32'(active), 32'h0);
        lock();
        check("relock_active", 32'(active), 32'h1);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        check("relock_valid_cnt", n_valid, 1);
        check("relock_word", last_word, 32'h77777777);

        // Reset mid-byte clears outputs at once; no relock without commas.
        do_reset();
        lock();
        send_byte(8'h44); send_byte(8'h44);
        tick(1'b0); tick(1'b1); tick(1'b0);
        reset = 1'b1;
        #1;
        check("midrst_active", 32'(active), 32'h0);
        check("midrst_lane", lane_out, 32'h0);
        model_reset();
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        clear_mon();
        for (int i = 0; i < 12; i++) send_byte(8'h44);
        check("midrst_no_active", 32'(active), 32'h0);
        check("midrst_no_valid", n_valid, 0);

        // Reset asserted while valid_out is high clears it immediately.
        do_reset();
        lock();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("pre_rst_valid", 32'(valid_out), 32'h1);
        check("pre_rst_word", lane_out, 32'hAABBCCDD);
        reset = 1'b1;
        #1;
        check("rst_kills_valid", 32'(valid_out), 32'h0);
        check("rst_kills_lane", lane_out, 32'h0);
        reset = 1'b0;

        // Vector table.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            lock();
            send_byte(vecs[v].b0); send_byte(vecs[v].b1);
            send_byte(vecs[v].b2); send_byte(vecs[v].b3);
            check("vec_valid", 32'(valid_out), 32'h1);
            check("vec_word", lane_out, vecs[v].word);
            check("vec_valid_cnt", n_valid, 1);
        end

        // Randomized symbol stream against the model.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int t = 0; t < 150; t++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    int unsigned k;
                    k = $urandom_range(1, 7);
                    for (int j = 0; j < int'(k); j++) tick(1'($urandom_range(0, 1)));
                end else if (r <= 3) begin
                    send_byte(COMMA);
                end else if (r == 4) begin
                    send_byte(IDLE);
                end else begin
                    send_byte(8'($urandom_range(0, 255)));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
